// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32M divide unit: operation codes, FSM states
// and the datapath width.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3[0] clear selects the signed variants, funct3[1] selects remainder
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module udiv_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] dvd,
    input  logic [W-1:0] dsr,
    output logic [W:0]   rem_nxt,
    output logic [W-2:0] dvd_nxt,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    // One spare bit above the partial remainder carries the trial sign
    assign shifted = {rem, dvd[W-1]};
    assign trial   = shifted - {2'b00, dsr};
    assign q_bit   = ~trial[W+1];
    assign rem_nxt = q_bit ? trial[W:0] : shifted[W:0];
    assign dvd_nxt = dvd[W-2:0];

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with register-file write-back
// packet; one quotient bit per cycle, special cases finish in one cycle.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wr_out,
    output logic            rf_we_out
);

    import cpu_pkg::*;

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  count;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   dsr_q;
    logic              is_rem_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        wr_q;

    logic              is_signed;
    logic              is_rem;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     rem_nxt;
    logic [XLEN-2:0]   dvd_nxt;
    logic              q_bit;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    assign is_signed = op_is_signed(op);
    assign is_rem    = op_is_rem(op);
    assign div_zero  = (rs2_data == '0);
    assign ovf       = is_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_data == '1);
    assign abs1      = (is_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    assign abs2      = (is_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

    // Overflow quotient equals the dividend (most negative value)
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? rs1_data : '1;
        else
            special_res = is_rem ? '0 : rs1_data;
    end

    udiv_step #(.W(XLEN)) u_step (
        .rem     (rem_q),
        .dvd     (dvd_q),
        .dsr     (dsr_q),
        .rem_nxt (rem_nxt),
        .dvd_nxt (dvd_nxt),
        .q_bit   (q_bit)
    );

    assign quo_nxt = {dvd_nxt, q_bit};
    assign q_fix   = q_neg_q ? -quo_nxt : quo_nxt;
    assign r_fix   = r_neg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = (div_zero || ovf) ? ST_DONE : ST_CALC;
            ST_CALC: if (count == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            wr_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        wr_q     <= rd_in;
                        is_rem_q <= is_rem;
                        q_neg_q  <= is_signed & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                        r_neg_q  <= is_signed & rs1_data[XLEN-1];
                        dvd_q    <= abs1;
                        dsr_q    <= abs2;
                        rem_q    <= '0;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            count    <= '0;
                        end else begin
                            count    <= CNT_W'(XLEN);
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_nxt;
                    dvd_q <= quo_nxt;
                    count <= count - CNT_W'(1);
                    // Sign fix-up lands in the result register on the last step
                    if (count == CNT_W'(1))
                        result_q <= is_rem_q ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rf_we_out = done;
    assign result    = result_q;
    assign wr_out    = wr_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operations push expected write-back
// packets; a negedge monitor pops and compares whenever done is seen.
module tb_div_unit;

    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wr_out;
    logic        rf_we_out;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wr_out    (wr_out),
        .rf_we_out (rf_we_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_sc = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("wr_out", {27'b0, wr_out}, {27'b0, mon_e.wr});
                chk("rf_we_out", {31'b0, rf_we_out}, 32'd1);
                chk("latency", cyc - last_sc + 1, mon_e.lat);
            end
            chk("done_pulse_prev", {31'b0, prev_done}, 32'd0);
        end
        prev_done = done;
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input int lat,
                         input bit push);
        @(negedge clk);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        if (push) sb.push_back('{er, rd, lat});
        @(posedge clk);
        #1;
        last_sc = cyc;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] er, input int lat);
        issue(o, a, b, rd, er, lat, 1'b1);
        wait_done(40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, rf_we_out}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wr", {27'b0, wr_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal path, back-to-back on the first IDLE cycle
        run(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 33);
        run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 33);
        run(OP_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 33);
        run(OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, 33);
        run(OP_REM,  32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FFFE, 33);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'd1, 33);
        run(OP_DIVU, 32'd5, 32'd10, 5'd14, 32'd0, 33);
        run(OP_REMU, 32'd5, 32'd10, 5'd15, 32'd5, 33);
        run(OP_DIV,  32'h8000_0000, 32'd1, 5'd16, 32'h8000_0000, 33);
        run(OP_DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 33);

        // Divide by zero and signed overflow finish in one cycle
        run(OP_DIV,  32'd12345, 32'd0, 5'd3, 32'hFFFF_FFFF, 1);
        run(OP_REMU, 32'd12345, 32'd0, 5'd4, 32'd12345, 1);
        run(OP_REM,  32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFF9, 1);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1);
        run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1);

        // Start during CALC is ignored
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 33, 1'b1);
        repeat (9) begin
            @(negedge clk);
            chk("busy_hold", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("busy_hold", {31'b0, busy}, 32'd1);
        op = OP_DIV; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk("busy_hold", {31'b0, busy}, 32'd1);
            if (done) break;
            @(negedge clk);
        end
        chk("ign_done_seen", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("busy_fall", {31'b0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("held_result", result, 32'hFFFF_FFFF);
        chk("held_wr", {27'b0, wr_out}, 32'd7);

        // Reset in cycle 15 of a DIV discards it
        issue(OP_DIV, 32'd1000, 32'd7, 5'd3, 32'd0, 0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
